// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and command word layout for the I2C scheduler.
package i2c_pkg;
  localparam int I2C_WORD_W = 24;
  localparam int SLAVE_HI = 23;
  localparam int SUB_HI = 15;
  localparam int DATA_HI = 7;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;
endpackage

// File: rtl/i2c_clk_div.sv
// i2c_clk_div: controller work clock; tick marks the 1->0 toggle, mid-low-phase launch point.
module i2c_clk_div #(
  parameter int DIV = 2500
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic ctl_clk,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;
  logic clk_q, clk_d, wrap;
  always_comb begin
    wrap = cnt_q == 16'(DIV);
    cnt_d = wrap ? '0 : cnt_q + 16'd1;
    clk_d = wrap ? ~clk_q : clk_q;
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  assign ctl_clk = clk_q;
  assign tick = wrap & clk_q;
endmodule

// File: rtl/i2c_cmd_sched.sv
// i2c_cmd_sched: round-robin command scheduler for one shared I2C_Controller with NACK retry.
module i2c_cmd_sched import i2c_pkg::*; #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter int N_REQ = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [I2C_WORD_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rsp_valid,
  output logic [1:0]                  rsp_id,
  output logic                        rsp_err,
  output logic                        busy,
  output logic                        ctl_clk,
  output logic [I2C_WORD_W-1:0]       ctl_data,
  output logic                        ctl_go,
  input  logic                        ctl_end,
  input  logic                        ctl_ack
);
  localparam int DIV = CLK_FREQ / I2C_FREQ;
  localparam int TW = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_id_q, gnt_id_d, g;
  logic [TW-1:0] tries_q, tries_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic [I2C_WORD_W-1:0] ctl_data_q, ctl_data_d;
  logic ctl_go_q, ctl_go_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, tick;
  i2c_clk_div #(.DIV(DIV)) u_div (.iCLK(iCLK), .iRST_N(iRST_N), .ctl_clk(ctl_clk), .tick(tick));
  // Scan downward so the requester closest at-or-after ptr wins.
  always_comb begin
    g = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(ptr_q) + k) % N_REQ]) g = 2'((int'(ptr_q) + k) % N_REQ);
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gnt_id_d = gnt_id_q;
    tries_d = tries_q;
    req_ready_d = '0;
    ctl_data_d = ctl_data_q;
    ctl_go_d = ctl_go_q;
    rsp_valid_d = 1'b0;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: if (|req_valid) begin
        req_ready_d[g] = 1'b1;
        ctl_data_d = req_data[I2C_WORD_W*int'(g) +: I2C_WORD_W];
        gnt_id_d = g;
        tries_d = '0;
        ptr_d = (g == 2'(N_REQ - 1)) ? 2'd0 : g + 2'd1;
        state_d = S_ISSUE;
      end
      S_ISSUE: if (tick) begin
        ctl_go_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: if (tick && ctl_end) begin
        ctl_go_d = 1'b0;
        if (ctl_ack && tries_q < TW'(MAX_RETRY)) begin
          tries_d = tries_q + 1'b1;
          state_d = S_GAP;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d = ctl_ack;
          state_d = S_DONE;
        end
      end
      S_GAP: state_d = tick ? S_ISSUE : S_GAP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      gnt_id_q <= '0;
      tries_q <= '0;
      req_ready_q <= '0;
      ctl_data_q <= '0;
      ctl_go_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gnt_id_q <= gnt_id_d;
      tries_q <= tries_d;
      req_ready_q <= req_ready_d;
      ctl_data_q <= ctl_data_d;
      ctl_go_q <= ctl_go_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
    end
  assign req_ready = req_ready_q;
  assign ctl_data = ctl_data_q;
  assign ctl_go = ctl_go_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = gnt_id_q;
  assign rsp_err = rsp_err_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_i2c_cmd_sched.sv
// tb_i2c_cmd_sched: directed table-driven checks plus contention, reset and divider sequences.
module tb_i2c_cmd_sched;
  logic iCLK = 1'b0, iRST_N = 1'b0, rst2_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [47:0] req_data = '0;
  logic rsp_valid, rsp_err, busy, ctl_clk, ctl_go;
  logic [1:0] rsp_id;
  logic [23:0] ctl_data;
  logic c_end = 1'b0, c_ack = 1'b0;
  logic [1:0] d_ready, d_id;
  logic d_valid, d_err, d_busy, d_clk, d_go;
  logic [23:0] d_data;
  int passed = 0, total = 0;
  int go_rises = 0, cmd_base = 0, plan = 0, m_cnt = 0;
  logic go_prev = 1'b0;

  always #5 iCLK = ~iCLK;

  // DIV = 4: work clock period of 10 iCLK cycles keeps the functional runs short.
  i2c_cmd_sched #(.CLK_FREQ(80000), .I2C_FREQ(20000), .N_REQ(2), .MAX_RETRY(3)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy), .ctl_clk(ctl_clk), .ctl_data(ctl_data), .ctl_go(ctl_go),
    .ctl_end(c_end), .ctl_ack(c_ack));

  i2c_cmd_sched u_def (
    .iCLK(iCLK), .iRST_N(rst2_n), .req_valid(2'b00), .req_data(48'd0),
    .req_ready(d_ready), .rsp_valid(d_valid), .rsp_id(d_id), .rsp_err(d_err),
    .busy(d_busy), .ctl_clk(d_clk), .ctl_data(d_data), .ctl_go(d_go),
    .ctl_end(1'b0), .ctl_ack(1'b0));

  always @(posedge iCLK) begin
    go_prev <= ctl_go;
    if (ctl_go && !go_prev) go_rises <= go_rises + 1;
  end

  // Controller model: END after four work-clock rises with GO; NACK the first 'plan' attempts.
  always @(posedge ctl_clk)
    if (!ctl_go) begin
      m_cnt <= 0;
      c_end <= 1'b0;
    end else if (m_cnt < 3) m_cnt <= m_cnt + 1;
    else begin
      c_end <= 1'b1;
      c_ack <= (go_rises - cmd_base) <= plan;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic send(input int r, input logic [23:0] d, output int lat);
    @(negedge iCLK);
    req_data[24*r +: 24] = d;
    req_valid[r] = 1'b1;
    lat = 0;
    do begin @(posedge iCLK); #1; lat++; end while (req_ready == 2'b00 && lat < 2000);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    do begin @(posedge iCLK); #1; n++; end while (!rsp_valid && n < 4000);
  endtask

  function automatic logic [63:0] outs();
    return 64'({req_ready, rsp_valid, rsp_id, rsp_err, busy, ctl_clk, ctl_go, ctl_data});
  endfunction

  typedef struct { int r; logic [23:0] d; int nacks; logic err; int att; } vec_t;
  vec_t v[5];

  initial begin
    int lat, n, rise_at, m, cnt0, cnt1, grants, rsps, last_g;
    logic saw_rsp, prev;
    v[0] = '{0, 24'h400880, 0, 1'b0, 1};
    v[1] = '{1, 24'h401234, 2, 1'b0, 3};
    v[2] = '{0, 24'h3A0102, 5, 1'b1, 4};
    v[3] = '{1, 24'h3AFFFF, 3, 1'b0, 4};
    v[4] = '{1, 24'hFFFFFF, 4, 1'b1, 4};
    repeat (3) @(negedge iCLK);
    chk("reset_outputs", outs(), 64'd0);
    iRST_N = 1'b1;
    repeat (2) @(posedge iCLK);
    for (int i = 0; i < 5; i++) begin
      cmd_base = go_rises;
      plan = v[i].nacks;
      send(v[i].r, v[i].d, lat);
      chk("grant_latency", 64'(lat), 64'd1);
      chk("req_ready", 64'(req_ready), 64'(2'b01 << v[i].r));
      chk("ctl_data", 64'(ctl_data), 64'(v[i].d));
      chk("busy_on_grant", 64'(busy), 64'd1);
      wait_rsp();
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(v[i].r));
      chk("rsp_err", 64'(rsp_err), 64'(v[i].err));
      chk("attempts", 64'(go_rises - cmd_base), 64'(v[i].att));
      chk("go_low_at_rsp", 64'(ctl_go), 64'd0);
      @(posedge iCLK); #1;
      chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
    end
    cmd_base = go_rises;
    plan = 10;
    send(0, 24'h123456, lat);
    n = 0;
    while (!ctl_go && n < 2000) begin @(posedge iCLK); #1; n++; end
    chk("go_before_reset", 64'(ctl_go), 64'd1);
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 64'd0);
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    rise_at = 0;
    saw_rsp = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge iCLK); #1;
      if (ctl_clk && rise_at == 0) rise_at = e;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("ctl_clk_restart", 64'(rise_at), 64'd5);
    chk("no_rsp_after_reset", 64'(saw_rsp), 64'd0);
    chk("idle_after_reset", 64'(busy), 64'd0);
    plan = 0;
    cmd_base = go_rises;
    cnt0 = 0; cnt1 = 0; grants = 0; rsps = 0; last_g = 0; n = 0;
    @(negedge iCLK);
    req_data = {24'h410000, 24'h4000A5};
    req_valid = 2'b11;
    while ((grants < 8 || rsps < 8) && n < 8000) begin
      @(posedge iCLK); #1;
      n++;
      if (req_ready != 2'b00) begin
        chk("cont_grant", 64'(req_ready), 64'(2'b01 << (grants % 2)));
        last_g = req_ready[1] ? 1 : 0;
        chk("cont_data", 64'(ctl_data), 64'({8'h40 + 8'(last_g), 8'(last_g ? cnt1 : cnt0), last_g ? 8'h00 : 8'hA5}));
        grants++;
        if (last_g == 1) begin
          cnt1++;
          if (cnt1 == 4) req_valid[1] = 1'b0; else req_data[47:24] = {8'h41, 8'(cnt1), 8'h00};
        end else begin
          cnt0++;
          if (cnt0 == 4) req_valid[0] = 1'b0; else req_data[23:0] = {8'h40, 8'(cnt0), 8'hA5};
        end
      end
      if (rsp_valid) begin
        chk("cont_rsp_id", 64'(rsp_id), 64'(last_g));
        rsps++;
      end
    end
    chk("cont_all_done", 64'(rsps), 64'd8);
    chk("cont_req0_served", 64'(cnt0), 64'd4);
    chk("cont_req1_served", 64'(cnt1), 64'd4);
    @(negedge iCLK);
    rst2_n = 1'b1;
    n = 0;
    do begin @(posedge iCLK); #1; n++; end while (!d_clk && n < 3000);
    chk("div_first_rise", 64'(n), 64'd2501);
    m = 0;
    prev = d_clk;
    do begin
      @(posedge iCLK); #1; m++;
      if (d_clk && !prev) break;
      prev = d_clk;
    end while (m < 6000);
    chk("div_period", 64'(m), 64'd5002);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
